dtc_cmd_exec_ctrl: RTL and testbench
====================================

Name: dtc_cmd_exec_ctrl

Overview:
Downstream consumer of the DTC command decoder's handshake (dtc_cmd_exec / rnw / feenal / addr / data).
- Turns each decoded command into one local register-bus transaction.
- Returns dtc_cmd_ack to the decoder.
- Serializes a reply frame (status plus read data) onto the DTC return line.
- Runs in the decoder's clock domain (clkin_n); the decoder's own ack timeout is 255 cycles.

Parameters:
TIMEOUT, 200, bus-access timeout in clkin_n cycles; must be < 255 so ack precedes the decoder's timeout
REPLY_HDR, 16'h00D1, reply frame header, sent MSB first
CNT_W, 16, width of completed-command counter

Ports:
clkin_n  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
dtc_cmd_exec  in  1  command valid level, held high until after ack
dtc_cmd_rnw  in  1  1 = read, 0 = write
dtc_cmd_feenal  in  1  target select: 1 = FPGA register space, 0 = ALTRO space
dtc_cmd_addr  in  20  register address
dtc_cmd_data  in  20  write data
dtc_cmd_ack  out  1  one-cycle completion pulse to decoder
bus_req  out  1  bus request, held until bus_ack, bus_err or timeout
bus_we  out  1  bus write enable (= ~rnw latched)
bus_sel  out  1  latched feenal
bus_addr  out  20  latched address
bus_wdata  out  20  latched write data
bus_ack  in  1  transaction done
bus_err  in  1  transaction failed
bus_rdata  in  20  read data, valid when bus_ack is high
dtc_reply  out  1  serial reply line, idle low
reply_busy  out  1  high while a reply frame is being shifted
cmd_cnt  out  CNT_W  completed commands, wraps
err_cnt  out  8  bus errors plus timeouts, saturates at 255
overrun  out  1  sticky; a command was dropped

Behaviour:
- Reset value of every output is 0; the FSM goes to IDLE and the pending flag clears. Reset mid-access drops bus_req the next edge; reset mid-frame forces dtc_reply low immediately on that edge.
- Command detection: a new command is a rising edge of exec (exec = 1 and exec_d = 0). A level held high after ack is never re-executed.
- FSM states: IDLE, ACCESS, ACK, TX.
- IDLE:
  - On edge or pending: latch rnw/feenal/addr/data into the bus_* outputs, assert bus_req and clear the timeout counter. bus_req is high the cycle after the edge.
  - Go to ACCESS.
- ACCESS:
  - The timeout counter increments each cycle.
  - bus_err high: status = 4'h1 and err_cnt increments. bus_err wins if bus_ack and bus_err are both high.
  - else bus_ack high: status = 4'h0; capture bus_rdata for reads, wdata echo for writes.
  - else counter == TIMEOUT-1: status = 4'h2 and err_cnt increments.
  - On any of these: drop bus_req and go to ACK.
- ACK:
  - dtc_cmd_ack = 1 for exactly this cycle; cmd_cnt increments.
  - Load the shift register with {REPLY_HDR, status, data20}, 40 bits.
  - Go to TX.
- TX:
  - dtc_reply = shift MSB, one bit per clock, 40 cycles.
  - reply_busy = 1 throughout.
  - After the last bit, dtc_reply returns low and the FSM goes to IDLE.
- Latency: exec edge at cycle 0 → bus_req at cycle 1. With bus_ack at cycle k, dtc_cmd_ack is at k+1, the first reply bit at k+2, and the line is idle at k+42.
- Edges during ACCESS, ACK or TX:
  - The first one sets pending and latches that command into a one-deep holding register.
  - A further edge while pending is set is dropped and sets overrun.
  - Pending is serviced from IDLE on the cycle after TX ends.
- Counter boundaries: cmd_cnt wraps all-ones → 0; err_cnt holds at 255.

Optional Feature:
DTC_REPLY_PARITY_EN
- Defined: one even-parity bit is appended over the 40 frame bits. The frame is 41 bits, TX lasts 41 cycles, and the line is idle at k+43.
- Undefined: 40-bit frame, no parity logic.

Test Plan:
- Write: exec edge with rnw = 0, feenal = 1, addr = 20'h00010, data = 20'h12345; bus_ack 3 cycles after bus_req → bus_we = 1, bus_addr = 20'h00010; ack pulse once; reply = 0x00D1, 4'h0, 20'h12345; cmd_cnt = 1.
- Read: rnw = 1, bus_rdata = 20'hABCDE with bus_ack → bus_we = 0; reply data = 20'hABCDE, status 4'h0.
- Timeout: bus_ack never asserted → bus_req drops after 200 cycles; ack pulse; status 4'h2; err_cnt = 1. bus_ack and bus_err together → status 4'h1.
- Held exec: exec held high for 300 cycles → exactly one bus_req and one ack. Two extra edges during TX → first serviced after the frame, second dropped, overrun = 1.
- Reset mid-TX at bit 20 → dtc_reply = 0 and all outputs 0 the next cycle; a following command executes normally.
- Parity build: with DTC_REPLY_PARITY_EN defined, the write case yields a 41-bit frame whose last bit makes the total ones count even.

Source files
------------

// File: rtl/dtc_cmd_exec_ctrl_if.sv
// rtl/dtc_cmd_exec_ctrl_if.sv - decoder handshake, register bus and reply signals of dtc_cmd_exec_ctrl
interface dtc_cmd_exec_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             dtc_cmd_exec;
  logic             dtc_cmd_rnw;
  logic             dtc_cmd_feenal;
  logic [19:0]      dtc_cmd_addr;
  logic [19:0]      dtc_cmd_data;
  logic             dtc_cmd_ack;
  logic             bus_req;
  logic             bus_we;
  logic             bus_sel;
  logic [19:0]      bus_addr;
  logic [19:0]      bus_wdata;
  logic             bus_ack;
  logic             bus_err;
  logic [19:0]      bus_rdata;
  logic             dtc_reply;
  logic             reply_busy;
  logic [CNT_W-1:0] cmd_cnt;
  logic [7:0]       err_cnt;
  logic             overrun;

  modport slave (
    input  dtc_cmd_exec, dtc_cmd_rnw, dtc_cmd_feenal, dtc_cmd_addr, dtc_cmd_data,
    output dtc_cmd_ack,
    output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    input  bus_ack, bus_err, bus_rdata,
    output dtc_reply, reply_busy, cmd_cnt, err_cnt, overrun
  );

  modport master (
    output dtc_cmd_exec, dtc_cmd_rnw, dtc_cmd_feenal, dtc_cmd_addr, dtc_cmd_data,
    input  dtc_cmd_ack,
    input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    output bus_ack, bus_err, bus_rdata,
    input  dtc_reply, reply_busy, cmd_cnt, err_cnt, overrun
  );
endinterface

// File: rtl/dtc_cmd_exec_ctrl.sv
// rtl/dtc_cmd_exec_ctrl.sv - executes decoded DTC commands on the register bus and shifts out a reply frame
// Optional DTC_REPLY_PARITY_EN appends an even-parity bit to the reply frame.
module dtc_cmd_exec_ctrl #(
  parameter int unsigned TIMEOUT   = 200,
  parameter logic [15:0] REPLY_HDR = 16'h00D1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clkin_n,
  input  logic                 reset,
  dtc_cmd_exec_ctrl_if.slave   io_dtc
);
`ifdef DTC_REPLY_PARITY_EN
  localparam int unsigned FRAME_W = 41;
`else
  localparam int unsigned FRAME_W = 40;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK, S_TX} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_exec_d;
  logic               r_pend;
  logic               r_hold_rnw;
  logic               r_hold_sel;
  logic [19:0]        r_hold_addr;
  logic [19:0]        r_hold_data;
  logic               r_bus_req;
  logic               r_bus_we;
  logic               r_bus_sel;
  logic [19:0]        r_bus_addr;
  logic [19:0]        r_bus_wdata;
  logic [7:0]         r_tcnt;
  logic [3:0]         r_status;
  logic [19:0]        r_rdata;
  logic [FRAME_W-1:0] r_shift;
  logic [5:0]         r_bcnt;
  logic [CNT_W-1:0]   r_cmd_cnt;
  logic [7:0]         r_err_cnt;
  logic               r_overrun;
  logic               w_edge;
  logic               w_timeout;
  logic               w_tx_last;
  logic [39:0]        w_frame;
  logic [FRAME_W-1:0] w_frame_full;

  assign w_edge    = io_dtc.dtc_cmd_exec & ~r_exec_d;
  assign w_timeout = (r_tcnt == 8'(TIMEOUT - 1));
  assign w_tx_last = (r_bcnt == 6'(FRAME_W - 1));
  assign w_frame   = {REPLY_HDR, r_status, r_rdata};
`ifdef DTC_REPLY_PARITY_EN
  assign w_frame_full = {w_frame, ^w_frame};
`else
  assign w_frame_full = w_frame;
`endif

  always_ff @(posedge clkin_n) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_edge || r_pend) w_next = S_ACCESS;
      S_ACCESS: if (io_dtc.bus_err || io_dtc.bus_ack || w_timeout) w_next = S_ACK;
      S_ACK:    w_next = S_TX;
      S_TX:     if (w_tx_last) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clkin_n) begin
    if (reset) begin
      r_exec_d    <= 1'b0;
      r_pend      <= 1'b0;
      r_hold_rnw  <= 1'b0;
      r_hold_sel  <= 1'b0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_tcnt      <= '0;
      r_status    <= '0;
      r_rdata     <= '0;
      r_shift     <= '0;
      r_bcnt      <= '0;
      r_cmd_cnt   <= '0;
      r_err_cnt   <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_exec_d <= io_dtc.dtc_cmd_exec;
      // One command may wait while busy; anything beyond that is lost.
      if (w_edge && r_pend) r_overrun <= 1'b1;
      if (w_edge && !r_pend && r_state != S_IDLE) begin
        r_pend      <= 1'b1;
        r_hold_rnw  <= io_dtc.dtc_cmd_rnw;
        r_hold_sel  <= io_dtc.dtc_cmd_feenal;
        r_hold_addr <= io_dtc.dtc_cmd_addr;
        r_hold_data <= io_dtc.dtc_cmd_data;
      end
      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            r_pend      <= 1'b0;
            r_bus_req   <= 1'b1;
            r_bus_we    <= ~r_hold_rnw;
            r_bus_sel   <= r_hold_sel;
            r_bus_addr  <= r_hold_addr;
            r_bus_wdata <= r_hold_data;
            r_tcnt      <= '0;
          end else if (w_edge) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= ~io_dtc.dtc_cmd_rnw;
            r_bus_sel   <= io_dtc.dtc_cmd_feenal;
            r_bus_addr  <= io_dtc.dtc_cmd_addr;
            r_bus_wdata <= io_dtc.dtc_cmd_data;
            r_tcnt      <= '0;
          end
        end
        S_ACCESS: begin
          r_tcnt <= r_tcnt + 8'd1;
          if (io_dtc.bus_err) begin
            r_bus_req <= 1'b0;
            r_status  <= 4'h1;
            r_rdata   <= '0;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end else if (io_dtc.bus_ack) begin
            r_bus_req <= 1'b0;
            r_status  <= 4'h0;
            r_rdata   <= r_bus_we ? r_bus_wdata : io_dtc.bus_rdata;
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_status  <= 4'h2;
            r_rdata   <= '0;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
        S_ACK: begin
          r_cmd_cnt <= r_cmd_cnt + CNT_W'(1);
          r_shift   <= w_frame_full;
          r_bcnt    <= '0;
        end
        S_TX: begin
          r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
          r_bcnt  <= r_bcnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Line is gated by state so a reset mid-frame drops it on the same edge.
  assign io_dtc.dtc_reply   = (r_state == S_TX) & r_shift[FRAME_W-1];
  assign io_dtc.reply_busy  = (r_state == S_TX);
  assign io_dtc.dtc_cmd_ack = (r_state == S_ACK);
  assign io_dtc.bus_req     = r_bus_req;
  assign io_dtc.bus_we      = r_bus_we;
  assign io_dtc.bus_sel     = r_bus_sel;
  assign io_dtc.bus_addr    = r_bus_addr;
  assign io_dtc.bus_wdata   = r_bus_wdata;
  assign io_dtc.cmd_cnt     = r_cmd_cnt;
  assign io_dtc.err_cnt     = r_err_cnt;
  assign io_dtc.overrun     = r_overrun;
endmodule

// File: tb/tb_dtc_cmd_exec_ctrl.sv
// tb/tb_dtc_cmd_exec_ctrl.sv - randomized self-checking bench for dtc_cmd_exec_ctrl
module tb_dtc_cmd_exec_ctrl;
  localparam int TIMEOUT = 200;
`ifdef DTC_REPLY_PARITY_EN
  localparam int FRAME = 41;
`else
  localparam int FRAME = 40;
`endif

  logic clkin_n = 1'b0;
  logic reset   = 1'b1;

  dtc_cmd_exec_ctrl_if #(.CNT_W(16)) dif ();

  dtc_cmd_exec_ctrl #(
    .TIMEOUT  (TIMEOUT),
    .REPLY_HDR(16'h00D1),
    .CNT_W    (16)
  ) dut (
    .clkin_n(clkin_n),
    .reset  (reset),
    .io_dtc (dif)
  );

  always #5 clkin_n = ~clkin_n;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cmd = 0;
  int exp_err = 0;
  logic exp_ovr = 1'b0;

  int   req_rises = 0;
  int   acks      = 0;
  logic req_q     = 1'b0;

  logic        p_rnw, p_sel;
  logic [19:0] p_addr, p_data;

  always @(negedge clkin_n) begin
    req_q <= dif.bus_req;
    if (dif.bus_req && !req_q) req_rises <= req_rises + 1;
    if (dif.dtc_cmd_ack) acks <= acks + 1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, want);
  endtask

  function automatic logic [FRAME-1:0] exp_frame(input logic [3:0] st, input logic [19:0] d);
    logic [39:0] f;
    int ones;
    f = {16'h00D1, st, d};
    ones = 0;
    for (int i = 0; i < 40; i++) ones += int'(f[i]);
`ifdef DTC_REPLY_PARITY_EN
    return {f, 1'(ones % 2)};
`else
    return f;
`endif
  endfunction

  task automatic rst_chk(input string tag);
    chk(tag, {dif.dtc_cmd_ack, dif.bus_req, dif.bus_we, dif.bus_sel, dif.dtc_reply,
              dif.reply_busy, dif.overrun, dif.cmd_cnt, dif.err_cnt}, 64'h0);
    chk(tag, {dif.bus_addr, dif.bus_wdata}, 64'h0);
  endtask

  task automatic start_cmd(input logic rnw, input logic sel, input logic [19:0] addr, input logic [19:0] data);
    @(negedge clkin_n);
    dif.dtc_cmd_rnw    = rnw;
    dif.dtc_cmd_feenal = sel;
    dif.dtc_cmd_addr   = addr;
    dif.dtc_cmd_data   = data;
    dif.dtc_cmd_exec   = 1'b1;
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 no response; mode: 0 normal, 1 hold exec, 2 two edges in TX, 3 reset at bit 20
  task automatic serve(input logic rnw, input logic sel, input logic [19:0] addr, input logic [19:0] wdata,
                       input int kind, input int dly, input logic [19:0] rdata, input int mode);
    int n, hi, busy_n;
    logic [3:0] st;
    logic [19:0] d;
    logic [FRAME-1:0] got;
    n = 0;
    do begin
      @(negedge clkin_n);
      n++;
    end while (dif.bus_req !== 1'b1 && n < 50);
    chk("req_latency", n, 1);
    chk("bus_fields", {dif.bus_we, dif.bus_sel, dif.bus_addr, dif.bus_wdata}, {~rnw, sel, addr, wdata});
    if (kind == 3) begin
      hi = 0;
      while (dif.bus_req === 1'b1 && hi < 400) begin
        hi++;
        @(negedge clkin_n);
      end
      chk("timeout_len", hi, TIMEOUT);
      st = 4'h2;
      d  = 20'h0;
    end else begin
      repeat (dly) @(negedge clkin_n);
      chk("req_hold", dif.bus_req, 1'b1);
      dif.bus_ack   = (kind != 1);
      dif.bus_err   = (kind != 0);
      dif.bus_rdata = rdata;
      @(negedge clkin_n);
      dif.bus_ack   = 1'b0;
      dif.bus_err   = 1'b0;
      dif.bus_rdata = 20'($urandom);
      st = (kind == 0) ? 4'h0 : 4'h1;
      d  = rnw ? rdata : wdata;
    end
    chk("ack_and_req_drop", {dif.dtc_cmd_ack, dif.bus_req}, 2'b10);
    if (mode != 1) dif.dtc_cmd_exec = 1'b0;
    exp_cmd++;
    if (st != 4'h0 && exp_err < 255) exp_err++;
    busy_n = 0;
    got = '0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clkin_n);
      if (i == 0) chk("ack_one_cycle", dif.dtc_cmd_ack, 1'b0);
      busy_n += int'(dif.reply_busy);
      got[FRAME-1-i] = dif.dtc_reply;
      if (mode == 3 && i == 20) begin
        reset = 1'b1;
        @(negedge clkin_n);
        rst_chk("reset_mid_tx");
        reset = 1'b0;
        exp_cmd = 0;
        exp_err = 0;
        exp_ovr = 1'b0;
        return;
      end
      if (mode == 2) begin
        case (i)
          5: begin
            dif.dtc_cmd_rnw = p_rnw; dif.dtc_cmd_feenal = p_sel;
            dif.dtc_cmd_addr = p_addr; dif.dtc_cmd_data = p_data;
            dif.dtc_cmd_exec = 1'b1;
          end
          7: dif.dtc_cmd_exec = 1'b0;
          9: begin
            dif.dtc_cmd_rnw = ~p_rnw; dif.dtc_cmd_addr = ~p_addr;
            dif.dtc_cmd_data = ~p_data; dif.dtc_cmd_exec = 1'b1;
            exp_ovr = 1'b1;
          end
          11: dif.dtc_cmd_exec = 1'b0;
          default: ;
        endcase
      end
    end
    @(negedge clkin_n);
    chk("busy_cycles", busy_n, FRAME);
    chk("line_idle", {dif.reply_busy, dif.dtc_reply}, 2'b00);
    if (kind == 0) chk("frame", got, exp_frame(st, d));
    else           chk("frame_hdr_status", got[FRAME-1 -: 20], {16'h00D1, st});
    chk("counters", {dif.cmd_cnt, dif.err_cnt}, {exp_cmd[15:0], exp_err[7:0]});
    chk("overrun", dif.overrun, exp_ovr);
  endtask

  int r0, a0, kind;
  logic        r_rnw, r_sel;
  logic [19:0] r_addr, r_data, r_rd;

  initial begin
    dif.dtc_cmd_exec = 1'b0; dif.dtc_cmd_rnw = 1'b0; dif.dtc_cmd_feenal = 1'b0;
    dif.dtc_cmd_addr = '0; dif.dtc_cmd_data = '0;
    dif.bus_ack = 1'b0; dif.bus_err = 1'b0; dif.bus_rdata = '0;
    repeat (3) @(negedge clkin_n);
    rst_chk("reset_state");
    reset = 1'b0;

    start_cmd(1'b0, 1'b1, 20'h00010, 20'h12345);
    serve(1'b0, 1'b1, 20'h00010, 20'h12345, 0, 3, 20'h00000, 0);
    start_cmd(1'b1, 1'b0, 20'h00020, 20'h0F0F0);
    serve(1'b1, 1'b0, 20'h00020, 20'h0F0F0, 0, 2, 20'hABCDE, 0);
    start_cmd(1'b1, 1'b1, 20'h00030, 20'h00000);
    serve(1'b1, 1'b1, 20'h00030, 20'h00000, 3, 0, 20'h00000, 0);
    start_cmd(1'b0, 1'b0, 20'h00040, 20'h55555);
    serve(1'b0, 1'b0, 20'h00040, 20'h55555, 2, 1, 20'h11111, 0);

    r0 = req_rises; a0 = acks;
    start_cmd(1'b0, 1'b1, 20'h00050, 20'h00777);
    serve(1'b0, 1'b1, 20'h00050, 20'h00777, 0, 0, 20'h0, 1);
    repeat (300) @(negedge clkin_n);
    chk("held_exec_reqs", req_rises - r0, 1);
    chk("held_exec_acks", acks - a0, 1);
    dif.dtc_cmd_exec = 1'b0;

    p_rnw = 1'b1; p_sel = 1'b0; p_addr = 20'($urandom); p_data = 20'($urandom);
    chk("overrun_before", dif.overrun, 1'b0);
    start_cmd(1'b0, 1'b1, 20'h00060, 20'h24680);
    serve(1'b0, 1'b1, 20'h00060, 20'h24680, 0, 1, 20'h0, 2);
    serve(p_rnw, p_sel, p_addr, p_data, 0, 2, 20'h13579, 0);

    start_cmd(1'b0, 1'b0, 20'h00070, 20'hFFFFF);
    serve(1'b0, 1'b0, 20'h00070, 20'hFFFFF, 0, 0, 20'h0, 3);
    start_cmd(1'b1, 1'b1, 20'h00080, 20'h00000);
    serve(1'b1, 1'b1, 20'h00080, 20'h00000, 0, 4, 20'h9ABCD, 0);

    for (int t = 0; t < 40; t++) begin
      r_rnw = 1'($urandom); r_sel = 1'($urandom);
      r_addr = 20'($urandom); r_data = 20'($urandom); r_rd = 20'($urandom);
      kind = $urandom_range(0, 9);
      kind = (kind < 6) ? 0 : (kind < 8) ? 1 : (kind == 8) ? 2 : 3;
      start_cmd(r_rnw, r_sel, r_addr, r_data);
      serve(r_rnw, r_sel, r_addr, r_data, kind, $urandom_range(0, 10), r_rd, 0);
    end

    for (int t = 0; t < 260; t++) begin
      r_addr = 20'($urandom); r_data = 20'($urandom);
      start_cmd(1'b0, 1'b0, r_addr, r_data);
      serve(1'b0, 1'b0, r_addr, r_data, 1 + int'($urandom_range(0, 1)), $urandom_range(0, 2), 20'h0, 0);
    end
    chk("err_cnt_saturated", dif.err_cnt, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
